// File: rtl/psum_drain.sv
// psum_drain
//   Collects one 36-bit partial-sum accumulator per PE column when that
//   column's done flag rises. Once every column has been captured, it drains
//   the columns in index order as rounded, saturated fix_8_8 words over a
//   valid/ready stream.
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   rst          : asynchronous active-high reset
//   sum_in       : N x 36-bit accumulators, column c at [36c+35:36c]
//                  (unsigned, 16 fractional bits)
//   calc_done_in : per-column done flags; a 0->1 transition requests capture
//   out_data     : converted fix_8_8 word
//   out_index    : column number of out_data
//   out_valid    : out_data/out_index/out_sat are valid
//   out_ready    : consumer accepts on out_valid & out_ready
//   out_sat      : out_data was clamped to 16'hFFFF
//   busy         : state is COLLECT or DRAIN
//   overrun      : sticky; a done edge arrived while draining and was dropped
module psum_drain #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [36*N-1:0] sum_in,
  input  logic [N-1:0]    calc_done_in,
  output logic [15:0]     out_data,
  output logic [IW-1:0]   out_index,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_sat,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t        r_state;
  logic [N-1:0]  r_done_q;
  logic [N-1:0]  r_captured;
  logic [35:0]   r_buf [N];
  logic [15:0]   r_out_data;
  logic [IW-1:0] r_out_index;
  logic          r_out_valid;
  logic          r_out_sat;
  logic          r_overrun;

  logic [N-1:0]  w_rise;
  logic [N-1:0]  w_cap;
  logic [N-1:0]  w_cap_next;
  logic          w_all;
  logic          w_hs;
  logic          w_last;
  logic [IW-1:0] w_next_idx;
  logic [35:0]   w_first_slot;
  logic [35:0]   w_conv_in;
  logic [36:0]   w_rnd;
  logic          w_conv_sat;
  logic [15:0]   w_conv_data;

  assign w_rise     = calc_done_in & ~r_done_q;
  // Edges are only honoured outside DRAIN and only for columns not yet held.
  assign w_cap      = (r_state != DRAIN) ? (w_rise & ~r_captured) : '0;
  assign w_cap_next = r_captured | w_cap;
  assign w_all      = &w_cap_next;
  assign w_hs       = r_out_valid & out_ready;
  assign w_last     = (r_out_index == IW'(N - 1));
  assign w_next_idx = r_out_index + 1'b1;

  // Slot 0 may be captured on the very edge that enters DRAIN, so the first
  // word is converted from the incoming value rather than the stale buffer.
  assign w_first_slot = w_cap[0] ? sum_in[35:0] : r_buf[0];
  assign w_conv_in    = (r_state == DRAIN) ? r_buf[w_next_idx] : w_first_slot;

  // (s + 0x80) >> 8 equals s[35:8] + s[7]; anything above 16 bits saturates,
  // which covers both nonzero s[35:24] and a rounding carry-out.
  always_comb begin
    w_rnd       = ({1'b0, w_conv_in} + 37'd128) >> 8;
    w_conv_sat  = (w_rnd > 37'h0_0000_FFFF);
    w_conv_data = w_conv_sat ? '1 : w_rnd[15:0];
  end

  // Slot storage is not reset; contents are meaningless until recaptured.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < N; c++) begin
      if (w_cap[c]) r_buf[c] <= sum_in[36*c +: 36];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_done_q    <= '0;
      r_captured  <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done_q <= calc_done_in;
      case (r_state)
        IDLE, COLLECT: begin
          r_captured <= w_cap_next;
          if (w_all) begin
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_out_index <= '0;
            r_out_data  <= w_conv_data;
            r_out_sat   <= w_conv_sat;
          end else if (|w_cap_next) begin
            r_state <= COLLECT;
          end
        end
        DRAIN: begin
          if (|w_rise) r_overrun <= 1'b1;
          if (w_hs) begin
            if (w_last) begin
              r_out_valid <= 1'b0;
              r_captured  <= '0;
              r_state     <= IDLE;
            end else begin
              r_out_index <= w_next_idx;
              r_out_data  <= w_conv_data;
              r_out_sat   <= w_conv_sat;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_valid = r_out_valid;
  assign out_sat   = r_out_sat;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule
